// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Adds two WIDTH-bit operands using a single 4-bit ripple adder. The adder
//   is reused once per nibble, least-significant nibble first. A registered
//   carry links each nibble to the next one.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request; only sampled while idle
//   a, b   operands; latched when start is accepted
//   cin    carry-in to nibble 0; latched when start is accepted
//   sub    (ADD_SUB_EN builds only) 1 = compute a - b; latched with the operands
//   busy   high while an operation is running or completing
//   done   one-cycle pulse; sum and cout are valid in that cycle
//   sum    registered result; holds until the next operation overwrites it
//   cout   registered carry out of the top nibble (1 = no borrow when subtracting)
//
// Build option
//   ADD_SUB_EN  when defined, adds the sub port and subtract mode.

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

// state  | meaning
// S_IDLE | waiting for start; busy=0
// S_RUN  | one nibble added per edge, idx selects the nibble
// S_DONE | result valid; done pulses for one cycle
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx;
  logic [IDXW+1:0]  base;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       nib_b, nib_sum;
  logic             nib_cout;
`ifdef ADD_SUB_EN
  logic             sub_q;
`endif

  assign base = {idx, 2'b00};

`ifdef ADD_SUB_EN
  // Subtract as a + ~b + 1; the +1 comes from the carry seeded at start.
  assign nib_b = sub_q ? ~b_q[base +: 4] : b_q[base +: 4];
`else
  assign nib_b = b_q[base +: 4];
`endif

  four_bit_adder u_add (
    .a    (a_q[base +: 4]),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef ADD_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
`ifdef ADD_SUB_EN
            sub_q <= sub;
            carry <= sub ? 1'b1 : cin;
`else
            carry <= cin;
`endif
          end
        end
        S_RUN: begin
          sum[base +: 4] <= nib_sum;
          carry          <= nib_cout;
          if (idx == LAST_IDX) begin
            cout <= nib_cout;
            idx  <= '0;
          end else begin
            idx  <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: whole-word arithmetic, {cout, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic ci, input logic s);
    logic [WIDTH:0] r;
`ifdef ADD_SUB_EN
    if (s) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
`else
    r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
    if (s) r = r;
`endif
    return r;
  endfunction

  // One operation with full timing checks. With noisy=1, start and the
  // operand inputs are scrambled while the operation is in flight.
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input logic xs, input bit noisy);
    logic [WIDTH:0] exp;
    exp = model(xa, xb, xc, xs);
    @(negedge clk);
    a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
    @(negedge clk);                       // edge 0 accepted the request
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check("busy_run0", busy, 1);
    check("done_run0", done, 0);
    for (int k = 1; k < NIBBLES; k++) begin
      if (noisy) start = 1'($urandom);
      @(negedge clk);
      check("busy_run", busy, 1);
      check("done_run", done, 0);
    end
    if (noisy) start = 1'($urandom);
    @(negedge clk);                       // after edge NIBBLES
    check("done_pulse", done, 1);
    check("busy_done", busy, 1);
    check("sum", sum, 32'(exp[WIDTH-1:0]));
    check("cout", cout, 32'(exp[WIDTH]));
    if (noisy) start = 1'b1;              // must be ignored in DONE
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("sum_hold", sum, 32'(exp[WIDTH-1:0]));
    check("cout_hold", cout, 32'(exp[WIDTH]));
  endtask

  initial begin
    int dones;
    int first_done;
    int last_done;
    logic [WIDTH:0] e;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h000F, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Start held high: one acceptance per NIBBLES+2 cycles.
    @(negedge clk);
    a = 16'h000F; b = 16'h0000; cin = 1'b1; sub = 1'b0; start = 1'b1;
    e = model(16'h000F, 16'h0000, 1'b1, 1'b0);
    dones = 0; first_done = -1; last_done = -1;
    for (int c = 0; c < 3 * (NIBBLES + 2); c++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = c;
        else check("held_spacing", c - last_done, NIBBLES + 2);
        last_done = c;
        dones++;
        check("held_sum", sum, 32'(e[WIDTH-1:0]));
      end
    end
    start = 1'b0;
    check("held_dones", dones, 3);
    check("held_first", first_done, NIBBLES);
    @(negedge clk);
    check("held_idle", busy, 0);

    // Reset mid-run discards the operation.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    rst = 1'b0;
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

`ifdef ADD_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
`ifdef ADD_SUB_EN
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`else
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 1'($urandom));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
